pim_dispatch_ctrl: RTL and testbench

PIM_DISPATCH_CTRL -- requirements
Module: pim_dispatch_ctrl

---
 rtl/pim_dispatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pim_dispatch_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_dispatch_ctrl.sv
// Chunk-job dispatcher for a pool of PIM units: hands out chunk indices and base
// addresses round-robin to free units and tracks completions until the run drains.
module pim_dispatch_ctrl #(
  parameter int NUM_UNITS    = 4,
  parameter int NUM_CHUNKS   = 256,
  parameter int CHUNK_STRIDE = 2,
  parameter int LEN          = 10,
  localparam int CW          = $clog2(NUM_CHUNKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        num_chunks,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [CW-1:0]        issue_chunk,
  output logic [LEN-1:0]       issue_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [LEN-1:0] STRIDE_L = LEN'(CHUNK_STRIDE);
  localparam logic [CW-1:0]  MAX_CHUNKS = CW'(NUM_CHUNKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        total_q, total_d;
  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        completed_q, completed_d;
  logic [NUM_UNITS-1:0] busy_mask_q, busy_mask_d;
  logic [UW-1:0]        rr_q, rr_d;
  logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
  logic [CW-1:0]        issue_chunk_q, issue_chunk_d;
  logic [LEN-1:0]       issue_addr_q, issue_addr_d;
  logic                 err_q, err_d;

  logic [NUM_UNITS-1:0] valid_done;
  logic [CW-1:0]        done_cnt;
  logic                 grant_valid;
  logic [UW-1:0]        grant_idx;
  logic [NUM_UNITS-1:0] grant_vec;
  logic [UW-1:0]        rr_next;
  logic [UW:0]          sum;
  logic [CW-1:0]        total_clamped;

  assign valid_done    = unit_done & busy_mask_q;
  assign total_clamped = (num_chunks > MAX_CHUNKS) ? MAX_CHUNKS : num_chunks;

  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      done_cnt = done_cnt + CW'(valid_done[i]);
    end
  end

  // Eligibility uses the mask as registered; a unit finishing this cycle waits one more.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sum = {1'b0, rr_q} + (UW+1)'(i);
      if (sum >= (UW+1)'(NUM_UNITS)) begin
        sum = sum - (UW+1)'(NUM_UNITS);
      end
      if (!grant_valid && !busy_mask_q[sum[UW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[UW-1:0];
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      grant_vec[i] = grant_valid && (grant_idx == UW'(i));
    end
  end

  always_comb begin
    if ({1'b0, grant_idx} + (UW+1)'(1) >= (UW+1)'(NUM_UNITS)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_idx + UW'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    total_d       = total_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    busy_mask_d   = busy_mask_q;
    rr_d          = rr_q;
    unit_start_d  = '0;
    issue_chunk_d = issue_chunk_q;
    issue_addr_d  = issue_addr_q;
    err_d         = err_q | (|(unit_done & ~busy_mask_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d     = total_clamped;
          issued_d    = '0;
          completed_d = '0;
          busy_mask_d = '0;
          err_d       = 1'b0;
          state_d     = (total_clamped == '0) ? S_FIN : S_DISPATCH;
        end
      end
      S_DISPATCH, S_DRAIN: begin
        busy_mask_d = busy_mask_q & ~valid_done;
        completed_d = completed_q + done_cnt;
        if (state_q == S_DISPATCH && grant_valid && issued_q < total_q) begin
          unit_start_d  = grant_vec;
          issue_chunk_d = issued_q;
          issue_addr_d  = LEN'(issued_q) * STRIDE_L;
          busy_mask_d   = busy_mask_d | grant_vec;
          issued_d      = issued_q + CW'(1);
          rr_d          = rr_next;
          if (issued_q + CW'(1) == total_q) begin
            state_d = S_DRAIN;
          end
        end
        // Completion can only catch up with total once every chunk has been issued.
        if (state_q == S_DRAIN && completed_d == total_q) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      total_q       <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      busy_mask_q   <= '0;
      rr_q          <= '0;
      unit_start_q  <= '0;
      issue_chunk_q <= '0;
      issue_addr_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_q       <= total_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      busy_mask_q   <= busy_mask_d;
      rr_q          <= rr_d;
      unit_start_q  <= unit_start_d;
      issue_chunk_q <= issue_chunk_d;
      issue_addr_q  <= issue_addr_d;
      err_q         <= err_d;
    end
  end

  assign unit_start  = unit_start_q;
  assign issue_chunk = issue_chunk_q;
  assign issue_addr  = issue_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;

endmodule

// File: tb/tb_pim_dispatch_ctrl.sv
// Self-checking bench for pim_dispatch_ctrl: randomized unit acknowledgements checked
// against a counter/array reference model of the dispatch rules.
module tb_pim_dispatch_ctrl;

  localparam int N   = 4;
  localparam int NC  = 256;
  localparam int CW  = $clog2(NC + 1);
  localparam int LEN = 10;

  logic           clk;
  logic           rst;
  logic           start;
  logic [CW-1:0]  num_chunks;
  logic [N-1:0]   unit_done;
  logic [N-1:0]   unit_start;
  logic [CW-1:0]  issue_chunk;
  logic [LEN-1:0] issue_addr;
  logic           busy;
  logic           done;
  logic           err;

  pim_dispatch_ctrl #(
    .NUM_UNITS(N), .NUM_CHUNKS(NC), .CHUNK_STRIDE(2), .LEN(LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks),
    .unit_done(unit_done), .unit_start(unit_start), .issue_chunk(issue_chunk),
    .issue_addr(issue_addr), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: run phase (0 idle, 1 running, 2 finishing), job counts, per-unit busy.
  int       m_phase, m_total, m_issued, m_completed, m_rr;
  bit [N-1:0] m_busy;
  bit       m_err;
  logic [N-1:0] e_us;
  int       e_chunk, e_addr;

  int obs_issues, obs_done, obs_last_addr;

  function automatic void model_reset();
    m_phase = 0; m_total = 0; m_issued = 0; m_completed = 0; m_rr = 0;
    m_busy = '0; m_err = 1'b0;
  endfunction

  function automatic logic [N-1:0] pick_acks(input int pct);
    logic [N-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++)
      if (m_busy[i] && $urandom_range(0, 99) < pct) a[i] = 1'b1;
    return a;
  endfunction

  task automatic step(input bit st, input int nch, input logic [N-1:0] ud);
    bit [N-1:0] old_busy;
    bit drain, granted;
    int u, n;
    @(negedge clk);
    start = st; num_chunks = CW'(nch); unit_done = ud;
    e_us = '0;
    case (m_phase)
      0: begin
        if (ud != '0) m_err = 1'b1;
        if (st) begin
          n = nch % 512;
          m_total = (n > NC) ? NC : n;
          m_issued = 0; m_completed = 0; m_busy = '0; m_err = 1'b0;
          m_phase = (m_total == 0) ? 2 : 1;
        end
      end
      1: begin
        old_busy = m_busy;
        drain = (m_issued == m_total);
        if ((ud & ~old_busy) != '0) m_err = 1'b1;
        for (int i = 0; i < N; i++) if (ud[i] && old_busy[i]) m_completed++;
        m_busy = m_busy & ~ud;
        granted = 1'b0;
        if (!drain) begin
          for (int k = 0; k < N; k++) begin
            u = (m_rr + k) % N;
            if (!granted && !old_busy[u]) begin
              granted = 1'b1;
              e_us[u] = 1'b1;
              e_chunk = m_issued;
              e_addr = (m_issued * 2) % (1 << LEN);
              m_busy[u] = 1'b1;
              m_issued++;
              m_rr = (u + 1) % N;
            end
          end
        end
        if (drain && m_completed == m_total) m_phase = 2;
      end
      default: begin
        if (ud != '0) m_err = 1'b1;
        m_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    unit_done = '0;
    vectors++;
    if (unit_start !== e_us) begin
      miscompares++;
      $display("FAIL unit_start: got %b expected %b", unit_start, e_us);
    end
    if (e_us != '0) begin
      vectors++;
      if (issue_chunk !== CW'(e_chunk) || issue_addr !== LEN'(e_addr)) begin
        miscompares++;
        $display("FAIL issue: got chunk %0d addr %0d expected chunk %0d addr %0d",
                 issue_chunk, issue_addr, e_chunk, e_addr);
      end
    end
    vectors++;
    if (busy !== (m_phase != 0) || done !== (m_phase == 2) || err !== m_err) begin
      miscompares++;
      $display("FAIL status: got busy %b done %b err %b expected %b %b %b",
               busy, done, err, m_phase != 0, m_phase == 2, m_err);
    end
    if (unit_start != '0) begin
      obs_issues++;
      obs_last_addr = int'(issue_addr);
    end
    if (done === 1'b1) obs_done++;
    $display("cyc st=%0d ud=%b us=%b chunk=%0d addr=%0d busy=%b done=%b err=%b",
             st, ud, unit_start, issue_chunk, issue_addr, busy, done, err);
  endtask

  task automatic finish_run(input int pct, input int spur_pct, input bit junk_start);
    int cyc = 0;
    logic [N-1:0] ud;
    int sp;
    while (m_phase != 0 && cyc < 3000) begin
      ud = pick_acks(pct);
      if (spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
        sp = $urandom_range(0, N - 1);
        if (!m_busy[sp]) ud[sp] = 1'b1;
      end
      step(junk_start && ($urandom_range(0, 7) == 0), $urandom_range(0, 40), ud);
      cyc++;
    end
    vectors++;
    if (m_phase != 0) begin
      miscompares++;
      $display("FAIL run_timeout: got no completion after %0d cycles, required completion", cyc);
    end
  endtask

  task automatic run(input int nch, input int pct, input int spur_pct);
    obs_issues = 0; obs_done = 0;
    step(1, nch, '0);
    finish_run(pct, spur_pct, 1'b1);
  endtask

  task automatic test_reset();
    start = 0; num_chunks = '0; unit_done = '0; rst = 0;
    #1 rst = 1;
    #1;
    vectors++;
    if (unit_start !== '0 || issue_chunk !== '0 || issue_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got us=%b chunk=%0d addr=%0d busy=%b done=%b err=%b required all 0",
               unit_start, issue_chunk, issue_addr, busy, done, err);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_basic_order();
    run(8, 100, 0);
    vectors++;
    if (obs_issues != 8 || obs_done != 1 || obs_last_addr != 14) begin
      miscompares++;
      $display("FAIL basic8: got issues %0d done %0d last_addr %0d required 8 1 14",
               obs_issues, obs_done, obs_last_addr);
    end
  endtask

  task automatic test_zero_chunks();
    obs_issues = 0; obs_done = 0;
    step(1, 0, '0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_fin: got done %b busy %b required 1 1", done, busy);
    end
    step(0, 0, '0);
    vectors++;
    if (obs_issues != 0 || obs_done != 1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_run: got issues %0d done %0d err %b required 0 1 0",
               obs_issues, obs_done, err);
    end
  endtask

  task automatic test_clamp();
    run(300, 100, 0);
    vectors++;
    if (obs_issues != 256 || obs_last_addr != 510 || obs_done != 1) begin
      miscompares++;
      $display("FAIL clamp: got issues %0d last_addr %0d done %0d required 256 510 1",
               obs_issues, obs_last_addr, obs_done);
    end
  endtask

  task automatic test_stall();
    obs_issues = 0; obs_done = 0;
    step(1, 6, '0);
    for (int i = 0; i < 8; i++) step(0, 0, '0);
    vectors++;
    if (obs_issues != 4) begin
      miscompares++;
      $display("FAIL stall: got issues %0d required 4", obs_issues);
    end
    step(0, 0, 4'b0100);
    step(0, 0, '0);
    vectors++;
    if (unit_start !== 4'b0100 || issue_chunk !== CW'(4)) begin
      miscompares++;
      $display("FAIL stall_resume: got us %b chunk %0d required 0100 4", unit_start, issue_chunk);
    end
    finish_run(60, 0, 1'b0);
  endtask

  task automatic test_err_sticky();
    step(1, 8, '0);
    step(0, 0, '0);
    step(0, 0, 4'b1000);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %b required 1", err);
    end
    finish_run(100, 0, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b required 1", err);
    end
  endtask

  task automatic test_reset_midrun();
    obs_done = 0;
    step(1, 10, '0);
    for (int i = 0; i < 3; i++) step(0, 0, '0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    vectors++;
    if (unit_start !== '0 || issue_chunk !== '0 || issue_addr !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset: got us=%b chunk=%0d addr=%0d busy=%b done=%b err=%b required 0",
               unit_start, issue_chunk, issue_addr, busy, done, err);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    step(0, 0, 4'b0001);
    step(0, 0, '0);
    vectors++;
    if (obs_done != 0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_after: got done_count %0d err %b required 0 1", obs_done, err);
    end
    step(1, 5, '0);
    step(0, 0, '0);
    vectors++;
    if (unit_start !== 4'b0001 || issue_chunk !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL restart: got us %b chunk %0d err %b required 0001 0 0",
               unit_start, issue_chunk, err);
    end
    finish_run(100, 0, 1'b0);
  endtask

  task automatic test_random();
    int nch;
    for (int r = 0; r < 12; r++) begin
      nch = ($urandom_range(0, 5) == 0) ? $urandom_range(250, 511) : $urandom_range(0, 24);
      run(nch, $urandom_range(20, 100), (r % 2 == 1) ? 6 : 0);
      vectors++;
      if (obs_done != 1) begin
        miscompares++;
        $display("FAIL random_done: run %0d got %0d done pulses required 1", r, obs_done);
      end
      step(0, 0, '0);
    end
  endtask

  initial begin
    model_reset();
    obs_issues = 0; obs_done = 0; obs_last_addr = 0;
    test_reset();
    test_basic_order();
    test_zero_chunks();
    test_clamp();
    test_stall();
    test_err_sticky();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
